mesh_dual_packer: RTL
=====================

MESH_DUAL_PACKER -- requirements
Module: mesh_dual_packer

Interface
REQ-001 SHALL have parameter W, default 8: payload width in bits.
REQ-002 SHALL have parameter X_SIZE, default 4: mesh columns; XW = $clog2(X_SIZE).
REQ-003 SHALL have parameter Y_SIZE, default 4: mesh rows; YW = $clog2(Y_SIZE).
REQ-004 SHALL have parameter BUFFER_DEPTH, default 4: pair-FIFO entries, power of two, >= 2.
REQ-005 SHALL have parameter FLUSH_TIMEOUT, default 4: idle cycles before a lone item is sent, >= 1.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports i_valid / i_dst_x / i_dst_y / i_payload  input  1/XW/YW/W  serial item stream.
REQ-009 SHALL have port i_ready  output  1  item accepted when i_valid & i_ready at clk edge.
REQ-010 SHALL have port i_flush  input  1  request immediate emission of a held lone item.
REQ-011 SHALL have ports o_valid_0 / o_dst_x_0 / o_dst_y_0 / o_payload_0  output  1/XW/YW/W  lane 0 (earlier item).
REQ-012 SHALL have ports o_valid_1 / o_dst_x_1 / o_dst_y_1 / o_payload_1  output  1/XW/YW/W  lane 1 (later item).
REQ-013 SHALL have port o_ready  input  1  beat transfers when (o_valid_0 | o_valid_1) & o_ready.

Function
REQ-014 SHALL pack the serial stream into two-lane beats; lane 0 always older than lane 1; flattened order (beat order, lane 0 then 1) equals input order.
REQ-015 SHALL implement packing FSM with states EMPTY (hold slot free) and HALF (one item in hold slot).
REQ-016 EMPTY: i_ready = 1; accepted item written to hold slot -> HALF, idle timer cleared to 0; no FIFO push.
REQ-017 HALF: i_ready = FIFO not full; accepted item pushes {slot, item} with both lane valids 1 -> EMPTY.
REQ-018 HALF, no item accepted: timer increments, saturating at FLUSH_TIMEOUT; timer width $clog2(FLUSH_TIMEOUT+1).
REQ-019 HALF, no item accepted, FIFO not full, and (i_flush or timer == FLUSH_TIMEOUT-1 before increment): push {slot, lane1 invalid} -> EMPTY.
REQ-020 HALF, FIFO full at timeout/flush: stay HALF, keep slot, retry every cycle until space; no data loss.
REQ-021 i_flush with simultaneous accepted item in HALF: pair push only (flush satisfied); i_flush in EMPTY: no effect.
REQ-022 Lane-1 fields of a single-item beat SHALL be driven 0.
REQ-023 FIFO SHALL hold BUFFER_DEPTH beats of 2*(1+XW+YW+W) bits with wrap-around pointers; push refused when full even if popping same cycle; pop when head valid and o_ready.
REQ-024 Outputs SHALL be FIFO head; all zero (both valids 0) when FIFO empty.
REQ-025 Latency: beat pushed at edge N visible on outputs after edge N (cycle N+1) if FIFO was empty.
REQ-026 Output fields SHALL hold stable while valid and o_ready low.
REQ-027 i_ready SHALL NOT depend combinationally on i_valid.

Reset
REQ-028 rst_n low SHALL immediately clear FSM to EMPTY, timer to 0, FIFO pointers/count to empty, all o_* to 0.
REQ-029 i_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-030 Reset mid-operation SHALL discard hold slot and FIFO contents; no beat emitted for pre-reset items.

Verification
REQ-031 o_ready=1; items A(x1,y2,0x11), B(x3,y0,0x22) back-to-back -> one beat lane0=A, lane1=B, both valids 1, one cycle after B accepted.
REQ-032 FLUSH_TIMEOUT=4; single item 0x33 then idle -> lone beat (o_valid_0=1, o_valid_1=0, lane1 fields 0) appears 5 cycles after acceptance.
REQ-033 Lone item 0x44 held, i_flush pulsed next cycle -> lone beat visible cycle after flush; no further beats.
REQ-034 o_ready=0; stream 2*BUFFER_DEPTH+1 items -> FIFO full, i_ready=0 in HALF, one item held; release o_ready -> all items out in order, none lost or duplicated.
REQ-035 rst_n asserted while FIFO holds 2 beats and slot full -> outputs 0 immediately; after release i_ready=1, first new pair emitted correctly with no stale data.
REQ-036 Random i_valid/o_ready/i_flush, 10k items -> scoreboard matches flattened order; every beat has o_valid_0=1 when any lane valid.

Source files
------------

// File: rtl/mesh_dual_packer.sv
`default_nettype none
// ============================================================================
// Module   : mesh_dual_packer
// Purpose  : Packs a serial stream of mesh-addressed items into two-lane
//            beats. Lane 0 always carries the older item. A lone item is
//            held until a partner arrives, a flush is requested, or an idle
//            timeout expires. Beats are buffered in a small pair FIFO whose
//            head drives the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mesh_dual_packer #(
  parameter int W             = 8,
  parameter int X_SIZE        = 4,
  parameter int Y_SIZE        = 4,
  parameter int BUFFER_DEPTH  = 4,
  parameter int FLUSH_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // serial item stream
  input  logic                      i_valid,
  input  logic [$clog2(X_SIZE)-1:0] i_dst_x,
  input  logic [$clog2(Y_SIZE)-1:0] i_dst_y,
  input  logic [W-1:0]              i_payload,
  output logic                      i_ready,
  input  logic                      i_flush,
  // lane 0 (earlier item)
  output logic                      o_valid_0,
  output logic [$clog2(X_SIZE)-1:0] o_dst_x_0,
  output logic [$clog2(Y_SIZE)-1:0] o_dst_y_0,
  output logic [W-1:0]              o_payload_0,
  // lane 1 (later item)
  output logic                      o_valid_1,
  output logic [$clog2(X_SIZE)-1:0] o_dst_x_1,
  output logic [$clog2(Y_SIZE)-1:0] o_dst_y_1,
  output logic [W-1:0]              o_payload_1,
  input  logic                      o_ready
);

  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int AW = $clog2(BUFFER_DEPTH);
  // one lane = valid + x + y + payload; an item is a lane without its valid
  localparam int LW = 1 + XW + YW + W;
  localparam int IW = LW - 1;
  localparam int EW = 2 * LW;

  localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(FLUSH_TIMEOUT - 1);
  localparam logic [TW-1:0] C_TIMEOUT_SAT  = TW'(FLUSH_TIMEOUT);
  localparam logic [AW:0]   C_DEPTH        = (AW + 1)'(BUFFER_DEPTH);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HALF  = 1'b1;

  // packing state
  logic [0:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [IW-1:0] r_slot;

  // pair FIFO
  logic [EW-1:0] r_mem [BUFFER_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_half;
  logic          w_accept;
  logic          w_timeout;
  logic          w_push_pair;
  logic          w_push_lone;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_item;
  logic [EW-1:0] w_push_entry;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_half  = (r_state == S_HALF);

  // Ready is a function of state only; held low throughout reset so no item
  // can be accepted while the datapath is being cleared.
  assign i_ready  = rst_n & (~w_half | ~w_full);
  assign w_accept = i_valid & i_ready;
  assign w_item   = {i_dst_x, i_dst_y, i_payload};

  // The timer saturates one past the last idle cycle, so ">=" keeps the
  // timeout asserted and retries every cycle while the FIFO stays full.
  assign w_timeout   = (r_timer >= C_TIMEOUT_LAST);
  assign w_push_pair = w_half & w_accept;
  assign w_push_lone = w_half & ~w_accept & ~w_full & (i_flush | w_timeout);
  assign w_push      = w_push_pair | w_push_lone;
  assign w_pop       = ~w_empty & o_ready;

  // Build the beat to enqueue: held item on lane 0, new item (or zeros) on lane 1
  always_comb begin
    w_push_entry = '0;
    if (w_push_pair) begin
      w_push_entry = {1'b1, r_slot, 1'b1, w_item};
    end else begin
      w_push_entry = {1'b1, r_slot, {LW{1'b0}}};
    end
  end

  // Hold-slot FSM with idle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_timer <= '0;
      r_slot  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_slot  <= w_item;
            r_timer <= '0;
            r_state <= S_HALF;
          end
        end
        S_HALF: begin
          if (!w_accept && (r_timer != C_TIMEOUT_SAT)) begin
            r_timer <= r_timer + 1'b1;
          end
          if (w_push) begin
            r_state <= S_EMPTY;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // FIFO storage; contents are only observable through r_count, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs present the FIFO head, forced to zero when nothing is queued
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign {o_valid_0, o_dst_x_0, o_dst_y_0, o_payload_0,
          o_valid_1, o_dst_x_1, o_dst_y_1, o_payload_1} = w_head;

endmodule
`default_nettype wire
